// File: rtl/sgm_pkg.sv
// Shared types and default geometry for the stereo SGM front end.
package sgm_pkg;

  typedef enum logic [2:0] {
    WAIT_VS,
    WAIT_DE,
    LEFT,
    RIGHT,
    OVERRUN
  } line_state_t;

  localparam int IMG_W_HALF_DEF = 640;
  localparam int IMG_H_DEF      = 720;
  localparam int MAX_DISP_DEF   = 64;

endpackage

// File: rtl/sync_edge_det.sv
// Registers a same-domain sync input and flags its rising edge combinationally.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/stereo_line_ctrl.sv
// Splits each active line of a side-by-side stereo stream into left/right halves
// and produces registered strobes, indices, frame markers and geometry errors.
//
// state   | meaning
// WAIT_VS | idle until a v_sync rising edge starts a frame
// WAIT_DE | between lines, waiting for the next de burst
// LEFT    | inside the left half of a line
// RIGHT   | inside the right half of a line
// OVERRUN | de held past a legal line end; strobes suppressed until de drops
module stereo_line_ctrl
  import sgm_pkg::*;
#(
  parameter int HALF_IMG_W = IMG_W_HALF_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int MAX_DISP   = MAX_DISP_DEF,
  parameter int COL_W      = $clog2(HALF_IMG_W),
  parameter int ROW_W      = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_in,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  output logic             left_we,
  output logic             right_we,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             disp_valid,
  output logic             line_err,
  output logic             frame_err
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(HALF_IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] DISP_COL = COL_W'(MAX_DISP - 1);

  line_state_t      state;
  logic [COL_W-1:0] cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             frame_done;
  logic             de_q;
  logic             hs_rise;
  logic             vs_rise;

  sync_edge_det u_hs_edge (.clk(clk), .rst_n(rst_n), .sig(h_sync_in), .rise(hs_rise));
  sync_edge_det u_vs_edge (.clk(clk), .rst_n(rst_n), .sig(v_sync_in), .rise(vs_rise));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_VS;
      cnt        <= '0;
      row_cnt    <= '0;
      frame_done <= 1'b0;
      de_q       <= 1'b0;
      left_we    <= 1'b0;
      right_we   <= 1'b0;
      col        <= '0;
      row        <= '0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      disp_valid <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      left_we    <= 1'b0;
      right_we   <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      disp_valid <= 1'b0;
      line_err   <= 1'b0;
      de_q       <= de_in;

      if (vs_rise) begin
        // A premature frame end keeps its error visible through the restarted frame.
        if (state == WAIT_VS || (state == WAIT_DE && row_cnt == '0)) frame_err <= 1'b0;
        else if (!frame_done)                                        frame_err <= 1'b1;
        state      <= WAIT_DE;
        row_cnt    <= '0;
        row        <= '0;
        cnt        <= '0;
        col        <= '0;
        frame_done <= 1'b0;
      end else begin
        case (state)
          WAIT_VS: begin
            if (eof && de_in) begin
              line_err  <= 1'b1;
              frame_err <= 1'b1;
              state     <= OVERRUN;
            end else if (frame_done && de_in && !de_q) begin
              frame_err <= 1'b1;
            end
          end

          WAIT_DE: begin
            if (de_in && eol) begin
              line_err  <= 1'b1;
              frame_err <= 1'b1;
              state     <= OVERRUN;
            end else if (de_in) begin
              left_we <= 1'b1;
              col     <= '0;
              row     <= row_cnt;
              sof     <= (row_cnt == '0);
              cnt     <= COL_W'(1);
              state   <= LEFT;
            end
          end

          LEFT, RIGHT: begin
            if (!de_in || hs_rise) begin
              line_err  <= 1'b1;
              frame_err <= 1'b1;
              cnt       <= '0;
              col       <= '0;
              if (row_cnt == LAST_ROW) begin
                frame_done <= 1'b1;
                state      <= WAIT_VS;
              end else begin
                row_cnt <= row_cnt + ROW_W'(1);
                state   <= WAIT_DE;
              end
            end else begin
              col <= cnt;
              row <= row_cnt;
              if (state == LEFT) begin
                left_we <= 1'b1;
                if (cnt == LAST_COL) begin
                  cnt   <= '0;
                  state <= RIGHT;
                end else begin
                  cnt <= cnt + COL_W'(1);
                end
              end else begin
                right_we   <= 1'b1;
                disp_valid <= (cnt >= DISP_COL);
                if (cnt == LAST_COL) begin
                  eol <= 1'b1;
                  cnt <= '0;
                  if (row_cnt == LAST_ROW) begin
                    eof        <= 1'b1;
                    frame_done <= 1'b1;
                    state      <= WAIT_VS;
                  end else begin
                    row_cnt <= row_cnt + ROW_W'(1);
                    state   <= WAIT_DE;
                  end
                end else begin
                  cnt <= cnt + COL_W'(1);
                end
              end
            end
          end

          OVERRUN: begin
            if (!de_in) state <= frame_done ? WAIT_VS : WAIT_DE;
          end

          default: state <= WAIT_VS;
        endcase
      end
    end
  end

endmodule
